// File: rtl/sobol_pkg.sv
// sobol_pkg: shared constants for the multi-dimension Sobol generator.
// Holds width/dimension limits, the Joe-Kuo direction table and dir_vec().
package sobol_pkg;

    localparam int MIN_RWID = 2;
    localparam int MAX_RWID = 16;
    localparam int MIN_DIM  = 1;
    localparam int MAX_DIM  = 4;
    localparam int ZW       = $clog2(MAX_RWID);

    // One direction vector per bit position, each MAX_RWID bits wide.
    typedef logic [MAX_RWID-1:0][MAX_RWID-1:0] dir_arr_t;

    // Primitive polynomial degree s for table row d (row 0 is van der Corput).
    function automatic int jk_s(input int d);
        case (d)
            1:       return 1;
            2:       return 2;
            3:       return 3;
            default: return 0;
        endcase
    endfunction

    // Polynomial interior coefficients a, MSB first (a_1 is bit s-2).
    function automatic int jk_a(input int d);
        case (d)
            2, 3:    return 1;
            default: return 0;
        endcase
    endfunction

    // Initial direction numbers m_1..m_s (k is zero-based).
    function automatic logic [31:0] jk_m_init(input int d, input int k);
        logic [31:0] m;
        m = 32'd1;
        if ((d == 2 || d == 3) && k == 1) begin
            m = 32'd3;
        end
        return m;
    endfunction

    // V_d[k] = m_d[k] << (rwid-1-k), with m extended by the recurrence
    // m_k = 2a_1 m_{k-1} ^ ... ^ 2^s m_{k-s} ^ m_{k-s}.
    function automatic dir_arr_t dir_vec(input int d, input int rwid);
        dir_arr_t                  v;
        logic [MAX_RWID-1:0][31:0] m;
        logic [31:0]               mk;
        int                        s;
        int                        a;
        v = '0;
        m = '0;
        s = jk_s(d);
        a = jk_a(d);
        for (int k = 0; k < rwid; k++) begin
            if (s == 0 || k < s) begin
                mk = jk_m_init(d, k);
            end else begin
                mk = m[k-s] ^ (m[k-s] << s);
                for (int j = 1; j < s; j++) begin
                    if (a[s-1-j]) begin
                        mk = mk ^ (m[k-j] << j);
                    end
                end
            end
            m[k] = mk;
            v[k] = MAX_RWID'(mk << (rwid - 1 - k));
        end
        return v;
    endfunction

endpackage

// File: rtl/sobol_rng_multi_lsz.sv
// lsz_enc: least-significant-zero priority encoder with all-ones flag.
// Ports: val_i word in; pos_o index of lowest 0 bit; all_ones_o no zero bit.
module lsz_enc #(
    parameter  int RWID = 8,
    localparam int CW   = $clog2(RWID)
) (
    input  logic [RWID-1:0] val_i,
    output logic [CW-1:0]   pos_o,
    output logic            all_ones_o
);

    // Scan from the top so the lowest zero bit wins.
    always_comb begin
        pos_o = '0;
        for (int i = RWID - 1; i >= 0; i--) begin
            if (!val_i[i]) begin
                pos_o = CW'(i);
            end
        end
    end

    assign all_ones_o = &val_i;

endmodule

// File: rtl/sobol_rng_multi.sv
// sobol_rng_multi: DIM-dimension Gray-code Sobol source with XOR scrambling.
// Ports: clk, rst_n (sync, low), enable, clear, shift_load, shift_in in;
//        sobol_seq (state ^ shift per dimension), idx, wrap pulse out.
module sobol_rng_multi
    import sobol_pkg::*;
#(
    parameter int RWID = 8,
    parameter int DIM  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                clear,
    input  logic                shift_load,
    input  logic [DIM*RWID-1:0] shift_in,
    output logic [DIM*RWID-1:0] sobol_seq,
    output logic [RWID-1:0]     idx,
    output logic                wrap
);

    localparam int CW = $clog2(RWID);

    if (RWID < MIN_RWID || RWID > MAX_RWID ||
        DIM < MIN_DIM || DIM > MAX_DIM) begin : g_bad_param
        $error("sobol_rng_multi: RWID or DIM out of range");
    end

    logic [RWID-1:0] idx_q, idx_d;
    logic            wrap_q, wrap_d;
    logic [CW-1:0]   zpos;
    logic [ZW-1:0]   zsel;
    logic            all_ones;

    lsz_enc #(.RWID(RWID)) u_lsz (
        .val_i     (idx_q),
        .pos_o     (zpos),
        .all_ones_o(all_ones)
    );

    assign zsel = ZW'(zpos);

    // A step from the all-ones index closes the period: back to 0, pulse wrap.
    always_comb begin
        idx_d  = idx_q;
        wrap_d = 1'b0;
        if (clear) begin
            idx_d = '0;
        end else if (enable) begin
            if (all_ones) begin
                idx_d  = '0;
                wrap_d = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            wrap_q <= wrap_d;
        end
    end

    for (genvar d = 0; d < DIM; d++) begin : g_dim
        localparam dir_arr_t V = dir_vec(d, RWID);

        logic [RWID-1:0] state_q, state_d;
        logic [RWID-1:0] shift_q, shift_d;

        always_comb begin
            state_d = state_q;
            if (clear) begin
                state_d = '0;
            end else if (enable) begin
                state_d = all_ones ? '0 : (state_q ^ V[zsel][RWID-1:0]);
            end
            shift_d = shift_load ? shift_in[d*RWID +: RWID] : shift_q;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_q <= '0;
                shift_q <= '0;
            end else begin
                state_q <= state_d;
                shift_q <= shift_d;
            end
        end

        assign sobol_seq[d*RWID +: RWID] = state_q ^ shift_q;
    end

    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_sobol_rng_multi.sv
// tb_sobol_rng_multi: vector table, corner sequences and random run
// for sobol_rng_multi at RWID=8/DIM=2 and RWID=4/DIM=4.
module tb_sobol_rng_multi;

    logic        clk;
    logic        rst_n;

    logic        a_en, a_clr, a_sl;
    logic [15:0] a_shin;
    logic [15:0] a_seq;
    logic [7:0]  a_idx;
    logic        a_wrap;

    logic        b_en, b_clr, b_sl;
    logic [15:0] b_shin;
    logic [15:0] b_seq;
    logic [3:0]  b_idx;
    logic        b_wrap;

    int n_vec;
    int n_err;

    sobol_rng_multi #(.RWID(8), .DIM(2)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (a_en),
        .clear     (a_clr),
        .shift_load(a_sl),
        .shift_in  (a_shin),
        .sobol_seq (a_seq),
        .idx       (a_idx),
        .wrap      (a_wrap)
    );

    sobol_rng_multi #(.RWID(4), .DIM(4)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (b_en),
        .clear     (b_clr),
        .shift_load(b_sl),
        .shift_in  (b_shin),
        .sobol_seq (b_seq),
        .idx       (b_idx),
        .wrap      (b_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        clr;
        logic        sl;
        logic [15:0] shin;
        logic [7:0]  e_idx;
        logic [7:0]  e0;
        logic [7:0]  e1;
        logic        e_wrap;
    } vec_t;

    vec_t tbl[10];
    int   ref8[2][256];
    int   ref4[4][16];

    int          mn;
    logic [7:0]  msh0, msh1;

    function automatic vec_t mkv(input int en, input int clr, input int sl,
                                 input int shin, input int ix, input int e0,
                                 input int e1, input int w);
        vec_t v;
        v.en     = en[0];
        v.clr    = clr[0];
        v.sl     = sl[0];
        v.shin   = shin[15:0];
        v.e_idx  = ix[7:0];
        v.e0     = e0[7:0];
        v.e1     = e1[7:0];
        v.e_wrap = w[0];
        return v;
    endfunction

    // Sample n of dimension d straight from the Gray code of n:
    // x = XOR of m_k << (rw-k) over the set bits k of gray(n).
    function automatic int ref_sample(input int d, input int n, input int rw);
        int m[17];
        int init[3][3];
        int s, a, g, x, mk;
        init = '{'{1, 0, 0}, '{1, 3, 0}, '{1, 3, 1}};
        case (d)
            1:       begin s = 1; a = 0; end
            2:       begin s = 2; a = 1; end
            3:       begin s = 3; a = 1; end
            default: begin s = 0; a = 0; end
        endcase
        for (int k = 0; k < 17; k++) m[k] = 0;
        for (int k = 1; k <= rw; k++) begin
            if (d == 0) begin
                m[k] = 1;
            end else if (k <= s) begin
                m[k] = init[d-1][k-1];
            end else begin
                mk = m[k-s] ^ (m[k-s] << s);
                for (int j = 1; j < s; j++) begin
                    if (((a >> (s - 1 - j)) & 1) != 0) mk = mk ^ (m[k-j] << j);
                end
                m[k] = mk;
            end
        end
        g = n ^ (n >> 1);
        x = 0;
        for (int k = 1; k <= rw; k++) begin
            if (((g >> (k - 1)) & 1) != 0) x = x ^ (m[k] << (rw - k));
        end
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic a_reset(input logic en, input logic sl,
                           input logic [15:0] shin);
        a_en   = en;
        a_clr  = 1'b0;
        a_sl   = sl;
        a_shin = shin;
        b_en   = 1'b0;
        rst_n  = 1'b0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        a_en   = 1'b0;
        a_sl   = 1'b0;
        a_shin = '0;
        mn     = 0;
        msh0   = '0;
        msh1   = '0;
    endtask

    task automatic a_step(input logic en, input logic clr, input logic sl,
                          input logic [15:0] shin, input string tag);
        logic ew;
        a_en   = en;
        a_clr  = clr;
        a_sl   = sl;
        a_shin = shin;
        ew = !clr && en && (mn == 255);
        if (clr) mn = 0;
        else if (en) mn = (mn + 1) % 256;
        if (sl) begin
            msh0 = shin[7:0];
            msh1 = shin[15:8];
        end
        @(posedge clk);
        #1;
        chk({tag, " idx"}, a_idx, mn);
        chk({tag, " d0"}, a_seq[7:0], ref8[0][mn] ^ msh0);
        chk({tag, " d1"}, a_seq[15:8], ref8[1][mn] ^ msh1);
        chk({tag, " wrap"}, a_wrap, ew);
    endtask

    initial begin
        int seen0[256];
        int seen1[256];
        int cnt0, cnt1, wraps;
        int sd[4][16];
        int bx[4][32];
        int qm, q;

        n_vec  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        a_en   = 1'b0;
        a_clr  = 1'b0;
        a_sl   = 1'b0;
        a_shin = '0;
        b_en   = 1'b0;
        b_clr  = 1'b0;
        b_sl   = 1'b0;
        b_shin = '0;

        for (int d = 0; d < 2; d++)
            for (int n = 0; n < 256; n++) ref8[d][n] = ref_sample(d, n, 8);
        for (int d = 0; d < 4; d++)
            for (int n = 0; n < 16; n++) ref4[d][n] = ref_sample(d, n, 4);

        tbl[0] = mkv(1, 0, 0, 16'h0000, 1, 128, 128, 0);
        tbl[1] = mkv(1, 0, 0, 16'h0000, 2, 192, 64, 0);
        tbl[2] = mkv(1, 0, 0, 16'h0000, 3, 64, 192, 0);
        tbl[3] = mkv(1, 0, 0, 16'h0000, 4, 96, 96, 0);
        tbl[4] = mkv(0, 0, 0, 16'h0000, 4, 96, 96, 0);
        tbl[5] = mkv(0, 0, 0, 16'h0000, 4, 96, 96, 0);
        tbl[6] = mkv(1, 0, 0, 16'h0000, 5, 224, 224, 0);
        tbl[7] = mkv(0, 0, 1, 16'hAA55, 5, 8'hB5, 8'h4A, 0);
        tbl[8] = mkv(1, 1, 0, 16'h0000, 0, 8'h55, 8'hAA, 0);
        tbl[9] = mkv(1, 0, 1, 16'h0000, 1, 128, 128, 0);

        a_reset(1'b0, 1'b0, 16'h0);
        chk("reset idx", a_idx, 0);
        chk("reset seq", a_seq, 0);
        chk("reset wrap", a_wrap, 0);
        chk("reset b seq", b_seq, 0);

        for (int i = 0; i < 10; i++) begin
            a_en   = tbl[i].en;
            a_clr  = tbl[i].clr;
            a_sl   = tbl[i].sl;
            a_shin = tbl[i].shin;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d idx", i), a_idx, tbl[i].e_idx);
            chk($sformatf("tbl%0d d0", i), a_seq[7:0], tbl[i].e0);
            chk($sformatf("tbl%0d d1", i), a_seq[15:8], tbl[i].e1);
            chk($sformatf("tbl%0d wrap", i), a_wrap, tbl[i].e_wrap);
        end

        // Full period plus overrun into the second period.
        a_reset(1'b0, 1'b0, 16'h0);
        for (int v = 0; v < 256; v++) begin
            seen0[v] = 0;
            seen1[v] = 0;
        end
        seen0[a_seq[7:0]] = 1;
        seen1[a_seq[15:8]] = 1;
        wraps = 0;
        for (int n = 1; n <= 276; n++) begin
            a_step(1'b1, 1'b0, 1'b0, 16'h0, "period");
            if (n < 256) begin
                seen0[a_seq[7:0]] = 1;
                seen1[a_seq[15:8]] = 1;
            end
            if (a_wrap) wraps++;
        end
        cnt0 = 0;
        cnt1 = 0;
        for (int v = 0; v < 256; v++) begin
            cnt0 += seen0[v];
            cnt1 += seen1[v];
        end
        chk("period cover d0", cnt0, 256);
        chk("period cover d1", cnt1, 256);
        chk("period wrap count", wraps, 1);

        // Clear at idx 37 with enable high and a live shift.
        a_reset(1'b0, 1'b0, 16'h0);
        a_step(1'b0, 1'b0, 1'b1, 16'h3C5A, "ld");
        for (int n = 0; n < 37; n++) a_step(1'b1, 1'b0, 1'b0, 16'h0, "to37");
        a_step(1'b1, 1'b1, 1'b0, 16'h0, "clr37");
        chk("clr37 seq eq shift", a_seq, 16'h3C5A);
        a_step(1'b1, 1'b0, 1'b0, 16'h0, "after clr37");

        // Clear on the would-be wrap step never pulses wrap.
        a_reset(1'b0, 1'b0, 16'h0);
        for (int n = 0; n < 255; n++) a_step(1'b1, 1'b0, 1'b0, 16'h0, "to255");
        a_step(1'b1, 1'b1, 1'b0, 16'h0, "clr255");
        a_step(1'b1, 1'b0, 1'b0, 16'h0, "after clr255");

        // Mid-run shift load, then reset overrides enable and shift_load.
        a_reset(1'b0, 1'b0, 16'h0);
        for (int n = 0; n < 10; n++) a_step(1'b1, 1'b0, 1'b0, 16'h0, "pre");
        a_step(1'b1, 1'b0, 1'b1, 16'hAA55, "shl");
        for (int n = 0; n < 15; n++) a_step(1'b1, 1'b0, 1'b0, 16'h0, "shrun");
        a_reset(1'b1, 1'b1, 16'hFFFF);
        chk("rst idx", a_idx, 0);
        chk("rst shift cleared", a_seq, 0);
        chk("rst wrap", a_wrap, 0);
        a_step(1'b1, 1'b0, 1'b0, 16'h0, "post rst");

        // Random control mix against the index/shift model.
        a_reset(1'b0, 1'b0, 16'h0);
        for (int n = 0; n < 1500; n++) begin
            a_step(($urandom % 4) != 0, ($urandom % 64) == 0,
                   ($urandom % 32) == 0, 16'($urandom), "rand");
        end

        // RWID=4, DIM=4 sweep over two periods.
        a_reset(1'b0, 1'b0, 16'h0);
        b_en = 1'b1;
        for (int n = 0; n < 32; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            chk($sformatf("b idx n%0d", n), b_idx, n % 16);
            chk($sformatf("b wrap n%0d", n), b_wrap, n == 16);
            for (int d = 0; d < 4; d++) begin
                bx[d][n] = int'(b_seq[d*4 +: 4]);
                chk($sformatf("b d%0d n%0d", d, n), bx[d][n], ref4[d][n % 16]);
            end
        end
        b_en = 1'b0;
        for (int d = 0; d < 4; d++) begin
            for (int v = 0; v < 16; v++) sd[d][v] = 0;
            for (int n = 0; n < 16; n++) sd[d][bx[d][n]] = 1;
            cnt0 = 0;
            for (int v = 0; v < 16; v++) cnt0 += sd[d][v];
            chk($sformatf("b cover d%0d", d), cnt0, 16);
        end
        for (int g = 0; g < 8; g++) begin
            qm = 0;
            for (int n = 4 * g; n < 4 * g + 4; n++) begin
                q  = ((bx[0][n] >> 3) & 1) * 2 + ((bx[1][n] >> 3) & 1);
                qm = qm | (1 << q);
            end
            chk($sformatf("b quad d01 g%0d", g), qm, 15);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
